// File: rtl/uart_sort_ctrl_if.sv
// rtl/uart_sort_ctrl_if.sv - handshake bundle between uart_rx/uart_tx glue and the byte sorter
interface uart_sort_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          i_Rx_DV;
  logic [7:0]    i_Rx_Byte;
  logic          i_Tx_Active;
  logic          i_Tx_Done;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          o_Busy;
  logic          o_Done;
  logic          o_Overrun;
  logic [CW-1:0] o_Rx_Count;

  // Driven by the UART side (or a bench), observed by the sorter.
  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Tx_DV, o_Tx_Byte, o_Busy, o_Done, o_Overrun, o_Rx_Count
  );

  // Sorter side.
  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done,
    output o_Tx_DV, o_Tx_Byte, o_Busy, o_Done, o_Overrun, o_Rx_Count
  );
endinterface

// File: rtl/uart_sort_ctrl.sv
// rtl/uart_sort_ctrl.sv - captures DEPTH bytes, bubble-sorts them, retransmits; UART_SORT_DESCENDING_EN selects largest-first order
module uart_sort_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic            i_Clock,
  input  logic            i_Rst_n,
  uart_sort_ctrl_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [IW-1:0] LAST_J = IW'(DEPTH - 2);
  localparam logic [IW-1:0] LAST_K = IW'(DEPTH - 1);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_RX,
    ST_SORT,
    ST_TX_ISSUE,
    ST_TX_WAIT,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] p_q, p_d;
  logic [IW-1:0] k_q, k_d;
  logic          tx_dv_q, tx_dv_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  logic [IW-1:0] j_nxt;
  logic          swap_needed;
  logic          issue_try;

  assign j_nxt = j_q + IW'(1);

`ifdef UART_SORT_DESCENDING_EN
  assign swap_needed = buf_q[j_q] < buf_q[j_nxt];
`else
  assign swap_needed = buf_q[j_q] > buf_q[j_nxt];
`endif

  // Next-state, datapath and registered-output decode for the whole frame cycle.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    p_d       = p_q;
    k_d       = k_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    overrun_d = 1'b0;
    issue_try = 1'b0;

    case (state_q)
      ST_RX: begin
        if (bus.i_Rx_DV) begin
          buf_d[cnt_q[IW-1:0]] = bus.i_Rx_Byte;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_C) begin
            state_d = ST_SORT;
            j_d     = '0;
            p_d     = '0;
          end
        end
      end
      ST_SORT: begin
        if (swap_needed) begin
          buf_d[j_q]   = buf_q[j_nxt];
          buf_d[j_nxt] = buf_q[j_q];
        end
        if (j_q == LAST_J - p_q) begin
          j_d = '0;
          if (p_q == LAST_J) begin
            // Last compare: the first byte can launch on this same edge.
            state_d   = ST_TX_ISSUE;
            k_d       = '0;
            issue_try = 1'b1;
          end else begin
            p_d = p_q + IW'(1);
          end
        end else begin
          j_d = j_nxt;
        end
      end
      ST_TX_ISSUE: begin
        issue_try = 1'b1;
      end
      ST_TX_WAIT: begin
        if (bus.i_Tx_Done) begin
          if (k_q == LAST_K) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + IW'(1);
            state_d = ST_TX_ISSUE;
          end
        end
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_RX;
      end
      default: begin
        state_d = ST_RX;
      end
    endcase

    // Bytes arriving while a frame is being sorted or sent are dropped.
    if (bus.i_Rx_DV && (state_q != ST_RX)) begin
      overrun_d = 1'b1;
    end

    // buf_d is used so the byte reflects the final swap of the sort.
    if (issue_try && !bus.i_Tx_Active) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = buf_d[k_d];
      state_d   = ST_TX_WAIT;
    end

    busy_d = (state_d == ST_SORT) || (state_d == ST_TX_ISSUE) || (state_d == ST_TX_WAIT);
    done_d = (state_d == ST_DONE);
  end

  // State, buffer and output registers.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_RX;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= 8'h00;
      end
      cnt_q     <= '0;
      j_q       <= '0;
      p_q       <= '0;
      k_q       <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      p_q       <= p_d;
      k_q       <= k_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.o_Tx_DV    = tx_dv_q;
  assign bus.o_Tx_Byte  = tx_byte_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Done     = done_q;
  assign bus.o_Overrun  = overrun_q;
  assign bus.o_Rx_Count = cnt_q;
endmodule

// File: tb/tb_uart_sort_ctrl.sv
// tb/tb_uart_sort_ctrl.sv - scoreboard bench for uart_sort_ctrl with a directed uart_tx responder
module tb_uart_sort_ctrl;
  localparam int DEPTH = 8;
  localparam int FW    = 8 * DEPTH;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_q [$];

  uart_sort_ctrl_if #(.DEPTH(DEPTH)) bus ();

  uart_sort_ctrl #(.DEPTH(DEPTH)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [FW-1:0] frm, input int i);
    return frm[8*(DEPTH-1-i) +: 8];
  endfunction

  task automatic push_expected(input logic [FW-1:0] frm);
    logic [7:0] a [DEPTH];
    logic [7:0] t;
    for (int i = 0; i < DEPTH; i++) a[i] = fbyte(frm, i);
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = i + 1; j < DEPTH; j++) begin
`ifdef UART_SORT_DESCENDING_EN
        if (a[j] > a[i]) begin t = a[i]; a[i] = a[j]; a[j] = t; end
`else
        if (a[j] < a[i]) begin t = a[i]; a[i] = a[j]; a[j] = t; end
`endif
      end
    end
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(a[i]);
  endtask

  // Called at a falling edge; the byte is captured on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_Rx_Byte = b;
    bus.i_Rx_DV   = 1'b1;
    @(negedge clk);
    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
  endtask

  task automatic send_frame(input logic [FW-1:0] frm);
    push_expected(frm);
    for (int i = 0; i < DEPTH; i++) send_byte(fbyte(frm, i));
  endtask

  // Acts as uart_tx: accepts each start strobe, stays active a few cycles, then signals done.
  task automatic serve_tx(input int n, input bit dv_in_done);
    int to;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      to = 0;
      while (!bus.o_Tx_DV && to < 300) begin
        @(negedge clk);
        to++;
      end
      chk("tx_dv_timeout", 32'(to < 300), 32'd1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      chk("tx_byte", 32'(bus.o_Tx_Byte), 32'(e));
      bus.i_Tx_Active = 1'b1;
      @(negedge clk);
      chk("tx_dv_single", 32'(bus.o_Tx_DV), 32'd0);
      repeat (2) @(negedge clk);
      chk("tx_byte_hold", 32'(bus.o_Tx_Byte), 32'(e));
      bus.i_Tx_Active = 1'b0;
      bus.i_Tx_Done   = 1'b1;
      @(negedge clk);
      bus.i_Tx_Done   = 1'b0;
      if (i == n - 1) begin
        chk("done_pulse", 32'(bus.o_Done), 32'd1);
        if (dv_in_done) begin
          bus.i_Rx_Byte = 8'hAA;
          bus.i_Rx_DV   = 1'b1;
          @(negedge clk);
          bus.i_Rx_DV   = 1'b0;
          chk("done_overrun", 32'(bus.o_Overrun), 32'd1);
        end else begin
          @(negedge clk);
        end
        chk("done_clear", 32'(bus.o_Done), 32'd0);
        chk("rx_count_clear", 32'(bus.o_Rx_Count), 32'd0);
        chk("busy_clear", 32'(bus.o_Busy), 32'd0);
      end else begin
        chk("done_early", 32'(bus.o_Done), 32'd0);
      end
    end
  endtask

  initial begin
    logic [FW-1:0] f1;
    logic [FW-1:0] frm;
    int n;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.i_Rx_DV = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    bus.i_Tx_Active = 1'b0;
    bus.i_Tx_Done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", 32'(bus.o_Tx_DV), 32'd0);
    chk("rst_tx_byte", 32'(bus.o_Tx_Byte), 32'd0);
    chk("rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("rst_done", 32'(bus.o_Done), 32'd0);
    chk("rst_overrun", 32'(bus.o_Overrun), 32'd0);
    chk("rst_rx_count", 32'(bus.o_Rx_Count), 32'd0);

    // Reference frame; first byte presented on the first edge after reset release.
    f1 = 64'h3F01FF80007E01C3;
    push_expected(f1);
    rst_n = 1'b1;
    send_byte(fbyte(f1, 0));
    chk("rx_count_first", 32'(bus.o_Rx_Count), 32'd1);
    for (int i = 1; i < DEPTH; i++) send_byte(fbyte(f1, i));
    chk("rx_count_full", 32'(bus.o_Rx_Count), 32'(DEPTH));
    n = 0;
    for (int c = 0; c < 100 && !bus.o_Tx_DV; c++) begin
      if (bus.o_Busy) n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'(DEPTH * (DEPTH - 1) / 2));
    serve_tx(DEPTH, 1'b0);

    // Back-to-back frame with duplicates; stray byte and stray tx done during sort.
    send_frame(64'h0505_0A00_FF05_0102);
    chk("rx_count_b2b", 32'(bus.o_Rx_Count), 32'(DEPTH));
    repeat (3) @(negedge clk);
    bus.i_Rx_Byte = 8'h55;
    bus.i_Rx_DV   = 1'b1;
    bus.i_Tx_Done = 1'b1;
    @(negedge clk);
    bus.i_Rx_DV   = 1'b0;
    bus.i_Tx_Done = 1'b0;
    chk("sort_overrun", 32'(bus.o_Overrun), 32'd1);
    @(negedge clk);
    chk("overrun_single", 32'(bus.o_Overrun), 32'd0);
    serve_tx(DEPTH, 1'b1);

    // Transmitter held busy long after the sort completes.
    bus.i_Tx_Active = 1'b1;
    send_frame(64'h10F0_20E0_30D0_40C0);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.o_Tx_DV) n++;
    end
    chk("no_dv_while_active", 32'(n), 32'd0);
    chk("busy_while_held", 32'(bus.o_Busy), 32'd1);
    bus.i_Tx_Active = 1'b0;
    @(negedge clk);
    chk("dv_after_release", 32'(bus.o_Tx_DV), 32'd1);
    serve_tx(DEPTH, 1'b0);

    // Asynchronous reset in the middle of a sort abandons the frame.
    send_frame(64'h9911_8822_7733_6644);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.o_Busy), 32'd0);
    chk("mid_rst_tx_dv", 32'(bus.o_Tx_DV), 32'd0);
    chk("mid_rst_tx_byte", 32'(bus.o_Tx_Byte), 32'd0);
    chk("mid_rst_rx_count", 32'(bus.o_Rx_Count), 32'd0);
    chk("mid_rst_overrun", 32'(bus.o_Overrun), 32'd0);
    chk("mid_rst_done", 32'(bus.o_Done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.o_Tx_DV || bus.o_Busy) n++;
    end
    chk("idle_after_rst", 32'(n), 32'd0);
    send_frame(64'h0807060504030201);
    serve_tx(DEPTH, 1'b0);

    // Random frame.
    for (int i = 0; i < DEPTH; i++) frm[8*i +: 8] = 8'($urandom_range(0, 255));
    send_frame(frm);
    serve_tx(DEPTH, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_sort_ctrl.md
UART_SORT_CTRL -- requirements
Module: uart_sort_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of bytes per sort frame (legal 2..16).
REQ-002 SHALL have port i_Clock, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_Rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port i_Rx_DV, input, 1, one-cycle strobe from uart_rx marking a valid received byte.
REQ-005 SHALL have port i_Rx_Byte, input, 8, received byte, valid while i_Rx_DV=1.
REQ-006 SHALL have port i_Tx_Active, input, 1, uart_tx busy indication.
REQ-007 SHALL have port i_Tx_Done, input, 1, one-cycle strobe from uart_tx at end of stop bit.
REQ-008 SHALL have port o_Tx_DV, output, 1, one-cycle start strobe to uart_tx.
REQ-009 SHALL have port o_Tx_Byte, output, 8, byte to transmit, held stable from o_Tx_DV until i_Tx_Done.
REQ-010 SHALL have port o_Busy, output, 1, high in SORT, TX_ISSUE and TX_WAIT.
REQ-011 SHALL have port o_Done, output, 1, one-cycle pulse after last byte of a frame is sent.
REQ-012 SHALL have port o_Overrun, output, 1, one-cycle pulse when an incoming byte is dropped.
REQ-013 SHALL have port o_Rx_Count, output, clog2(DEPTH)+1, bytes stored in current frame.

Function
REQ-014 SHALL implement states RX, SORT, TX_ISSUE, TX_WAIT, DONE; DONE lasts exactly one cycle.
REQ-015 In RX, each i_Rx_DV SHALL write i_Rx_Byte to buffer[o_Rx_Count] and increment o_Rx_Count.
REQ-016 The DEPTH-th i_Rx_DV SHALL store the byte and move to SORT on the same edge; o_Rx_Count then reads DEPTH.
REQ-017 SORT SHALL perform bubble sort: one compare (and swap if required) of buffer[j], buffer[j+1] per cycle; pass p runs j=0..DEPTH-2-p, p=0..DEPTH-2.
REQ-018 SORT SHALL last exactly DEPTH*(DEPTH-1)/2 cycles (28 for DEPTH=8); no early exit.
REQ-019 Swap SHALL occur only on strict inequality (unsigned 8-bit compare), so equal bytes never swap.
REQ-020 After SORT, TX_ISSUE SHALL assert o_Tx_DV for one cycle with o_Tx_Byte=buffer[k], only when i_Tx_Active=0; otherwise it waits.
REQ-021 TX_WAIT SHALL wait for i_Tx_Done; then k increments and returns to TX_ISSUE, or goes to DONE if k=DEPTH-1.
REQ-022 o_Tx_DV SHALL never assert twice for the same byte nor while i_Tx_Active=1.
REQ-023 DONE SHALL pulse o_Done, clear o_Rx_Count to 0, and return to RX.
REQ-024 i_Rx_DV outside RX SHALL be ignored (buffer unchanged) and SHALL pulse o_Overrun the next cycle.
REQ-025 i_Rx_DV in the DONE cycle SHALL count as overrun; frame capture restarts only in RX.
REQ-026 i_Tx_Done outside TX_WAIT SHALL be ignored.

Reset
REQ-027 Assertion of i_Rst_n=0 SHALL, asynchronously at any state including mid-SORT or mid-TX, force state RX and o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Done=0, o_Overrun=0, o_Rx_Count=0.
REQ-028 Buffer contents SHALL be don't-care after reset; a fresh frame always overwrites all DEPTH entries before SORT.
REQ-029 First i_Rx_DV accepted SHALL be on the first rising edge after i_Rst_n deasserts.

Configuration
REQ-030 Macro UART_SORT_DESCENDING_EN defined: swap when buffer[j] < buffer[j+1], transmitting largest first.
REQ-031 Macro UART_SORT_DESCENDING_EN undefined: swap when buffer[j] > buffer[j+1], transmitting smallest first; all timing identical in both builds.

Verification
REQ-032 Ascending: rx 3F,01,FF,80,00,7E,01,C3 -> tx 00,01,01,3F,7E,80,C3,FF; o_Busy high 28 cycles before first o_Tx_DV; o_Done one cycle after 8th i_Tx_Done.
REQ-033 Descending build, same input -> tx FF,C3,80,7E,3F,01,01,00.
REQ-034 Extra byte 55 on i_Rx_DV during SORT -> o_Overrun pulses once; transmitted frame unchanged.
REQ-035 i_Rst_n low for 1 cycle mid-SORT -> all outputs at reset values, no o_Tx_DV; next 8-byte frame 08..01 -> tx 01..08.
REQ-036 Hold i_Tx_Active=1 for 200 cycles after SORT -> o_Tx_DV stays 0, asserts exactly once on the cycle after i_Tx_Active drops.
REQ-037 Back-to-back frames: second frame bytes after o_Done -> captured from o_Rx_Count=0 and sorted independently.
